// File: rtl/fetch_sequencer_pkg.sv
// Shared types and helpers for the KGP-RISC fetch sequencer.
package kgp_fetch_pkg;

   localparam int PC_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_e;

   // Word-address bits needed to index a memory of the given depth.
   function automatic int addr_bits(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: decode handshake, redirect/halt controls and imem port.
interface fetch_sequencer_if
   import kgp_fetch_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) ();
   logic            stall;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_target;
   logic            halt;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_data;
   logic [31:0]     instr;
   logic [PC_W-1:0] instr_pc;
   logic            instr_valid;
   logic            halted;

   modport master (
      input  stall, redirect_valid, redirect_target, halt, imem_data,
      output imem_addr, instr, instr_pc, instr_valid, halted
   );

   modport slave (
      output stall, redirect_valid, redirect_target, halt, imem_data,
      input  imem_addr, instr, instr_pc, instr_valid, halted
   );
endinterface

// File: rtl/fetch_sequencer_hold_buf.sv
// One-entry hold register keeping the stalled instruction while imem moves on.
module fetch_hold_buf
   import kgp_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic        show_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] instr_o,
   output logic        full_o
);
   logic [31:0] hold_q;
   logic        full_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= '0;
         full_q <= 1'b0;
      end else if (clear_i) begin
         hold_q <= '0;
         full_q <= 1'b0;
      end else if (load_i) begin
         hold_q <= imem_data_i;
         full_q <= 1'b1;
      end
   end

   // Nothing is shown to decode when neither the hold nor the live word is valid.
   always_comb begin
      instr_o = '0;
      if (full_q) begin
         instr_o = hold_q;
      end else if (show_i) begin
         instr_o = imem_data_i;
      end
   end

   assign full_o = full_q;
endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer and fetch controller for KGP-RISC (1-cycle synchronous imem).
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
   import kgp_fetch_pkg::*;
#(
   parameter int              PC_W       = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC   = '0,
   parameter int              IMEM_DEPTH = 1024
) (
   input  logic clk,
   input  logic rst,
   fetch_sequencer_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall_cyc
`endif
);
   localparam int              AW      = addr_bits(IMEM_DEPTH);
   localparam logic [PC_W-1:0] LAST_PC = PC_W'(IMEM_DEPTH - 1);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] instr_pc_q, instr_pc_d;
   logic            valid_q, valid_d;
   logic            live_q, live_d;
   logic            hold_load, hold_clear, hold_full;
   logic [PC_W-1:0] next_pc, redir_pc;
   logic            unused_target_bits;

   assign next_pc  = (pc_q == LAST_PC) ? '0 : pc_q + PC_W'(1);
   assign redir_pc = PC_W'(bus.redirect_target[AW-1:0]);
   assign unused_target_bits = ^bus.redirect_target;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         live_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         live_q     <= live_d;
      end
   end

   // live_q marks that the word now being read from imem belongs to the stream;
   // it is clear only for the warm-up cycle after reset.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      live_d     = live_q;
      hold_load  = 1'b0;
      hold_clear = 1'b0;
      case (state_q)
         ST_HALT: begin
         end
         default: begin
            if (bus.halt) begin
               state_d    = ST_HALT;
               valid_d    = 1'b0;
               hold_clear = 1'b1;
            end else if (bus.redirect_valid) begin
               state_d    = ST_RUN;
               pc_d       = redir_pc;
               valid_d    = 1'b0;
               live_d     = 1'b1;
               hold_clear = 1'b1;
            end else if (bus.stall) begin
               if (state_q == ST_RUN && valid_q) begin
                  hold_load = 1'b1;
                  state_d   = ST_STALL;
               end
            end else begin
               state_d    = ST_RUN;
               hold_clear = hold_full;
               if (live_q) begin
                  pc_d       = next_pc;
                  instr_pc_d = pc_q;
                  valid_d    = 1'b1;
               end else begin
                  live_d = 1'b1;
               end
            end
         end
      endcase
   end

   fetch_hold_buf u_hold (
      .clk         (clk),
      .rst         (rst),
      .load_i      (hold_load),
      .clear_i     (hold_clear),
      .show_i      (valid_q),
      .imem_data_i (bus.imem_data),
      .instr_o     (bus.instr),
      .full_o      (hold_full)
   );

   assign bus.imem_addr   = pc_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = valid_q;
   assign bus.halted      = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else if (state_q != ST_HALT) begin
         if (valid_q && !bus.stall) begin
            perf_fetched_q <= perf_fetched_q + 32'd1;
         end
         if (bus.stall) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_fetched   = perf_fetched_q;
   assign perf_stall_cyc = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Random + directed bench for fetch_sequencer at IMEM_DEPTH 1024 and 16,
// checked every cycle against a stream-level model of the fetch sequence.
module tb_fetch_sequencer;
   localparam int NI = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, redirect_valid, halt;
   logic [31:0] redirect_target;

   always #5 clk = ~clk;

   logic [31:0] d_addr[NI], d_instr[NI], d_ipc[NI];
   logic        d_valid[NI], d_halted[NI];
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] d_pf[NI], d_ps[NI];
`endif

   function automatic int unsigned depth_of(input int i);
      return (i == 0) ? 1024 : 16;
   endfunction

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         localparam int DEPTH = (gi == 0) ? 1024 : 16;
         fetch_sequencer_if #(.PC_W(32)) bus ();
         assign bus.stall           = stall;
         assign bus.redirect_valid  = redirect_valid;
         assign bus.redirect_target = redirect_target;
         assign bus.halt            = halt;
         always @(posedge clk) bus.imem_data <= 32'h100 + bus.imem_addr;

         fetch_sequencer #(.PC_W(32), .RESET_PC(32'd0), .IMEM_DEPTH(DEPTH)) dut (
            .clk            (clk),
            .rst            (rst),
            .bus            (bus)
`ifdef FETCH_PERF_CNT_EN
            ,
            .perf_fetched   (d_pf[gi]),
            .perf_stall_cyc (d_ps[gi])
`endif
         );

         assign d_addr[gi]   = bus.imem_addr;
         assign d_instr[gi]  = bus.instr;
         assign d_ipc[gi]    = bus.instr_pc;
         assign d_valid[gi]  = bus.instr_valid;
         assign d_halted[gi] = bus.halted;
      end
   endgenerate

   // Model: fpc = next word to fetch, (v, vpc) = instruction decode is shown.
   bit          m_warm[NI], m_v[NI], m_halt[NI];
   int unsigned m_fpc[NI], m_vpc[NI], m_pf[NI], m_ps[NI];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", name, inst, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_warm[i] = 0; m_v[i] = 0; m_halt[i] = 0;
         m_fpc[i] = 0; m_vpc[i] = 0; m_pf[i] = 0; m_ps[i] = 0;
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < NI; i++) begin
            if (!m_halt[i]) begin
               if (m_v[i] && !stall) m_pf[i]++;
               if (stall) m_ps[i]++;
            end
            if (m_halt[i]) begin
            end else if (halt) begin
               m_halt[i] = 1; m_v[i] = 0;
            end else if (redirect_valid) begin
               m_fpc[i] = redirect_target % depth_of(i);
               m_v[i] = 0; m_warm[i] = 1;
            end else if (stall) begin
            end else if (!m_warm[i]) begin
               m_warm[i] = 1;
            end else begin
               m_v[i] = 1; m_vpc[i] = m_fpc[i];
               m_fpc[i] = (m_fpc[i] + 1) % depth_of(i);
            end
         end
      end
   endtask

   task automatic compare();
      for (int i = 0; i < NI; i++) begin
         chk("instr_valid", i, 32'(d_valid[i]), 32'(m_v[i]));
         chk("halted", i, 32'(d_halted[i]), 32'(m_halt[i]));
         chk("imem_addr", i, d_addr[i], m_fpc[i]);
         if (m_v[i]) begin
            chk("instr_pc", i, d_ipc[i], m_vpc[i]);
            chk("instr", i, d_instr[i], 32'h100 + m_vpc[i]);
         end else begin
            chk("instr_idle", i, d_instr[i], 32'd0);
         end
`ifdef FETCH_PERF_CNT_EN
         chk("perf_fetched", i, d_pf[i], m_pf[i]);
         chk("perf_stall_cyc", i, d_ps[i], m_ps[i]);
`endif
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
      $display("txn t=%0t st=%0b rd=%0b hl=%0b | i0 v=%0b pc=%0h ins=%0h a=%0h | i1 v=%0b pc=%0h a=%0h",
               $time, stall, redirect_valid, halt, d_valid[0], d_ipc[0], d_instr[0], d_addr[0],
               d_valid[1], d_ipc[1], d_addr[1]);
   endtask

   // Asserts rst between edges, checks immediate clear, releases it mid-cycle.
   task automatic do_reset();
      #2 rst = 1'b0;
      #1 model_reset();
      compare();
      chk("rst_valid", 0, 32'(d_valid[0]), 32'd0);
      chk("rst_addr", 0, d_addr[0], 32'd0);
      chk("rst_ipc", 0, d_ipc[0], 32'd0);
      chk("rst_instr", 0, d_instr[0], 32'd0);
      chk("rst_halted", 0, 32'(d_halted[0]), 32'd0);
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

   task automatic lit(input string name, input int inst, input bit v, input logic [31:0] pc);
      chk({name, "_v"}, inst, 32'(d_valid[inst]), 32'(v));
      if (v) begin
         chk({name, "_pc"}, inst, d_ipc[inst], pc);
         chk({name, "_instr"}, inst, d_instr[inst], 32'h100 + pc);
      end
   endtask

   initial begin
      rst = 1'b1; stall = 0; redirect_valid = 0; halt = 0; redirect_target = '0;
      do_reset();
      step(); lit("warmup", 0, 0, 0);
      step(); lit("first", 0, 1, 0);
      for (int k = 1; k <= 5; k++) begin
         step(); lit("seq", 0, 1, k);
      end
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         step(); lit("stall", 0, 1, 5);
         chk("stall_addr", 0, d_addr[0], 32'd6);
      end
      stall = 0;
      step(); lit("unstall", 0, 1, 6);

      redirect_valid = 1; redirect_target = 32'h40;
      step(); lit("squash", 0, 0, 0);
      redirect_valid = 0;
      step(); lit("target", 0, 1, 32'h40);
      redirect_valid = 1; stall = 1;
      step(); lit("squash_st", 0, 0, 0);
      redirect_valid = 0; stall = 0;
      step(); lit("target_st", 0, 1, 32'h40);

      redirect_valid = 1; redirect_target = 32'h13;
      step(); redirect_valid = 0;
      step(); lit("mod16", 1, 1, 3);
      redirect_valid = 1; redirect_target = 32'd14;
      step(); redirect_valid = 0;
      step(); lit("wrap14", 1, 1, 14);
      step(); lit("wrap15", 1, 1, 15);
      step(); lit("wrap0", 1, 1, 0);
      step(); lit("wrap1", 1, 1, 1);

      redirect_valid = 1; redirect_target = 32'd7;
      step(); redirect_valid = 0;
      step(); lit("pre_halt", 0, 1, 7);
      halt = 1;
      step(); halt = 0;
      lit("halt", 0, 0, 0);
      chk("halted", 0, 32'(d_halted[0]), 32'd1);
      redirect_valid = 1; redirect_target = 32'h20;
      step(); redirect_valid = 0;
      chk("halt_addr", 0, d_addr[0], 32'd8);
      chk("halt_hold", 0, 32'(d_halted[0]), 32'd1);

      do_reset();
      step(); lit("rwarm", 0, 0, 0);
      step(); lit("rfirst", 0, 1, 0);
      for (int k = 0; k < 10; k++) step();
      stall = 1;
      for (int k = 0; k < 3; k++) step();
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched_10", 0, d_pf[0], 32'd10);
      chk("perf_stall_3", 0, d_ps[0], 32'd3);
`endif
      lit("stalled", 0, 1, 10);
      do_reset();
      stall = 0;

      for (int n = 0; n < 2500; n++) begin
         if (($urandom % 200) == 0 || (m_halt[0] && ($urandom % 10) == 0)) begin
            do_reset();
         end
         stall           = (($urandom % 10) < 3);
         redirect_valid  = (($urandom % 100) < 8);
         halt            = (($urandom % 1000) < 6);
         redirect_target = ($urandom % 4 == 0) ? ($urandom % 48) : $urandom;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
